// File: rtl/mont_inv_batch_pkg.sv
// BN254 parameters, queue entry type, FSM encodings and modular helpers shared by
// the batched inverter and its operand queue.
package PARAMS_BN254_d0;

    localparam int MOD_W       = 254;
    localparam int TILDE12_W   = 268;
    localparam int DP_W        = MOD_W + 2;
    localparam int RED_STEPS   = TILDE12_W - MOD_W + 1;
    localparam int MONT_R_BITS = 256;
    localparam int PH2_TARGET  = 2 * MONT_R_BITS;
    localparam int KW          = 10;

    typedef logic [TILDE12_W-1:0] M_tilde12_t;

    localparam M_tilde12_t Mod =
        268'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef struct packed {
        logic [8:0] addr;
        M_tilde12_t data;
    } inv_entry_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_REDUCE = 3'd3;
    localparam logic [2:0] S_PH1    = 3'd4;
    localparam logic [2:0] S_PH2    = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;

    // Both helpers expect a < n, and return a value that is again < n.
    function automatic logic [DP_W-1:0] mod_dbl(input logic [DP_W-1:0] a,
                                                input logic [DP_W-1:0] n);
        logic [DP_W-1:0] t;
        t = a << 1;
        return (t >= n) ? t - n : t;
    endfunction

    function automatic logic [DP_W-1:0] mod_half(input logic [DP_W-1:0] a,
                                                 input logic [DP_W-1:0] n);
        logic [DP_W-1:0] t;
        t = a[0] ? a + n : a;
        return t >> 1;
    endfunction

endpackage

// File: rtl/mont_inv_batch_fifo.sv
// Synchronous operand queue for the inverter: show-ahead read, pushes into a full
// queue are dropped.
module mont_inv_fifo
    import PARAMS_BN254_d0::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = $bits(inv_entry_t)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mont_inv_batch.sv
// Batched Montgomery-domain inverter (Kaliski almost-inverse plus correction).
// Define MONT_INV_CONST_TIME_EN to run phase 1 for a fixed 2*MOD_W iterations.
module mont_inv_batch
    import PARAMS_BN254_d0::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 I_START,
    input  logic [TILDE12_W-1:0] I_DATA_N,
    input  logic [8:0]           I_WADDR,
    input  logic [TILDE12_W-1:0] I_WDATA,
    output logic                 O_BUSY,
    output logic                 O_WE,
    output logic [8:0]           O_WADDR,
    output logic [TILDE12_W-1:0] O_WDATA
);

    logic [2:0]           state;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    inv_entry_t           fifo_wdata;
    inv_entry_t           fifo_rdata;
    logic [TILDE12_W-1:0] rem;
    logic [TILDE12_W-1:0] dsh;
    logic [TILDE12_W-1:0] rem_step;
    logic [DP_W-1:0]      nmod;
    logic [DP_W-1:0]      u, v, r, s;
    logic [DP_W-1:0]      it_u, it_v, it_r, it_s;
    logic [DP_W-1:0]      red_r, fin_r, ph2_r;
    logic [KW-1:0]        k, it_k, cnt, ph2_cnt;
    logic                 ph2_halve;
    logic                 halve;
    logic                 zero;
    logic                 ph1_done;
    logic [8:0]           addr;

    assign nmod       = I_DATA_N[DP_W-1:0];
    assign fifo_wdata = {I_WADDR, I_WDATA};
    assign fifo_push  = I_START && !fifo_full && (state == S_IDLE || state == S_LOAD);
    assign fifo_pop   = (state == S_FETCH);
    assign O_BUSY     = (state != S_IDLE) || !fifo_empty;

    mont_inv_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(inv_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One Kaliski iteration; with v already zero it degenerates to a modular
    // doubling of r so that N - r keeps tracking x^-1 * 2^k.
    always_comb begin
        rem_step = (rem >= dsh) ? rem - dsh : rem;
        it_u = u;
        it_v = v;
        it_r = r;
        it_s = s;
        if (v == '0) begin
            it_r = mod_dbl(r, nmod);
        end else if (!u[0]) begin
            it_u = u >> 1;
            it_s = s << 1;
        end else if (!v[0]) begin
            it_v = v >> 1;
            it_r = r << 1;
        end else if (u > v) begin
            it_u = (u - v) >> 1;
            it_r = r + s;
            it_s = s << 1;
        end else begin
            it_v = (v - u) >> 1;
            it_s = s + r;
            it_r = r << 1;
        end
        it_k  = k + KW'(1);
        red_r = (it_r >= nmod) ? it_r - nmod : it_r;
        fin_r = nmod - red_r;
        if (it_k <= KW'(PH2_TARGET)) begin
            ph2_cnt   = KW'(PH2_TARGET) - it_k;
            ph2_halve = 1'b0;
        end else begin
            ph2_cnt   = it_k - KW'(PH2_TARGET);
            ph2_halve = 1'b1;
        end
        ph2_r = halve ? mod_half(r, nmod) : mod_dbl(r, nmod);
    end

`ifdef MONT_INV_CONST_TIME_EN
    assign ph1_done = (cnt == KW'(1));
`else
    assign ph1_done = (it_v == '0);
`endif

    // Sequencer and datapath registers; O_WE is a one-cycle pulse while in WRITE.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= S_IDLE;
            O_WE    <= 1'b0;
            O_WADDR <= '0;
            O_WDATA <= '0;
        end else begin
            O_WE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_START)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    if (!I_START)
                        state <= fifo_empty ? S_IDLE : S_FETCH;
                end
                S_FETCH: begin
                    addr  <= fifo_rdata.addr;
                    rem   <= fifo_rdata.data;
                    dsh   <= I_DATA_N << (RED_STEPS - 1);
                    cnt   <= KW'(RED_STEPS - 1);
                    state <= S_REDUCE;
                end
                S_REDUCE: begin
                    rem <= rem_step;
                    dsh <= dsh >> 1;
                    cnt <= cnt - KW'(1);
                    if (cnt == '0) begin
                        u    <= nmod;
                        v    <= rem_step[DP_W-1:0];
                        r    <= '0;
                        s    <= DP_W'(1);
                        k    <= '0;
                        zero <= (rem_step == '0);
`ifdef MONT_INV_CONST_TIME_EN
                        cnt   <= KW'(2 * MOD_W);
                        state <= S_PH1;
`else
                        if (rem_step == '0) begin
                            cnt   <= KW'(PH2_TARGET);
                            halve <= 1'b0;
                            state <= S_PH2;
                        end else begin
                            state <= S_PH1;
                        end
`endif
                    end
                end
                S_PH1: begin
                    u   <= it_u;
                    v   <= it_v;
                    s   <= it_s;
                    k   <= it_k;
                    r   <= (it_v == '0) ? red_r : it_r;
                    cnt <= cnt - KW'(1);
                    if (ph1_done) begin
                        r     <= fin_r;
                        cnt   <= ph2_cnt;
                        halve <= ph2_halve;
                        if (ph2_cnt == '0) begin
                            state   <= S_WRITE;
                            O_WE    <= 1'b1;
                            O_WADDR <= addr;
                            O_WDATA <= zero ? '0 : TILDE12_W'(fin_r);
                        end else begin
                            state <= S_PH2;
                        end
                    end
                end
                S_PH2: begin
                    r   <= ph2_r;
                    cnt <= cnt - KW'(1);
                    if (cnt == KW'(1)) begin
                        state   <= S_WRITE;
                        O_WE    <= 1'b1;
                        O_WADDR <= addr;
                        O_WDATA <= zero ? '0 : TILDE12_W'(ph2_r);
                    end
                end
                S_WRITE: begin
                    state <= fifo_empty ? S_IDLE : S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_inv_batch.sv
// Scoreboard bench for mont_inv_batch: expected inverses come from a Fermat-based
// model (x^(N-2) * 2^512 mod N) and are matched against write-backs in order.
module tb_mont_inv_batch;

    localparam int TW        = 268;
    localparam int DEPTH     = 8;
    localparam int OP_CYCLES = 529;
    localparam logic [TW-1:0] NMOD =
        268'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef struct {
        logic [8:0]    addr;
        logic [TW-1:0] data;
    } sbEntry_t;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [TW-1:0] dataN;
    logic [8:0]    waddr;
    logic [TW-1:0] wdata;
    logic          busy;
    logic          we;
    logic [8:0]    oWaddr;
    logic [TW-1:0] oWdata;

    sbEntry_t      sbQueue[$];
    int            checkCount = 0;
    int            errorCount = 0;
    int            batchCount = 0;
    int            writeCount = 0;
    int            expectedWrites = 0;
    longint        cycleCount = 0;
    longint        lastWeCycle = 0;
    bit            moreFollow = 0;
    bit            expectIdleNext = 0;
    logic [TW-1:0] r2Model;
    logic [TW-1:0] r256Model;

    mont_inv_batch #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .I_START  (start),
        .I_DATA_N (dataN),
        .I_WADDR  (waddr),
        .I_WDATA  (wdata),
        .O_BUSY   (busy),
        .O_WE     (we),
        .O_WADDR  (oWaddr),
        .O_WDATA  (oWdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                               input logic [TW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [TW-1:0] modMul(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [2*TW-1:0] p;
        p = {{TW{1'b0}}, a} * {{TW{1'b0}}, b};
        return TW'(p % {{TW{1'b0}}, NMOD});
    endfunction

    function automatic logic [TW-1:0] pow2Mod(input int e);
        logic [2*TW-1:0] b;
        b = 1;
        b = b << e;
        return TW'(b % {{TW{1'b0}}, NMOD});
    endfunction

    function automatic logic [TW-1:0] expectedFor(input logic [TW-1:0] x);
        logic [TW-1:0] xr;
        logic [TW-1:0] e;
        logic [TW-1:0] acc;
        xr = x % NMOD;
        if (xr == '0)
            return '0;
        e   = NMOD - TW'(2);
        acc = TW'(1);
        for (int i = TW - 1; i >= 0; i--) begin
            acc = modMul(acc, acc);
            if (e[i])
                acc = modMul(acc, xr);
        end
        return modMul(acc, r2Model);
    endfunction

    function automatic logic [TW-1:0] randOperand();
        logic [287:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return t[TW-1:0];
    endfunction

    // Holds I_START high for holdCycles edges; entries beyond the queue depth
    // are dropped by the DUT and therefore never enter the scoreboard.
    task automatic applyStimulus(input logic [8:0] addr, input logic [TW-1:0] data,
                                 input int holdCycles, input logic [TW-1:0] expected);
        start = 1'b1;
        waddr = addr;
        wdata = data;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            if (batchCount < DEPTH) begin
                sbQueue.push_back('{addr: addr, data: expected});
                expectedWrites++;
            end
            batchCount++;
            #1;
        end
    endtask

    task automatic endBatch();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idleWithinBudget", TW'(busy), TW'(0));
        checkOutput("sbDrained", TW'(sbQueue.size()), TW'(0));
        batchCount = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Write-back monitor: order, address, value, spacing and busy fall.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            if (expectIdleNext) begin
                checkOutput("busyFall", TW'(busy), TW'(0));
                expectIdleNext = 0;
            end
            if (we === 1'b1) begin
                writeCount++;
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedWrite", TW'(1), TW'(0));
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("waddr", TW'(oWaddr), TW'(e.addr));
                    checkOutput("wdata", oWdata, e.data);
                    if (moreFollow)
                        checkOutput("writeSpacing", TW'(cycleCount - lastWeCycle), TW'(OP_CYCLES));
                    moreFollow     = (sbQueue.size() > 0);
                    expectIdleNext = !moreFollow;
                end
                lastWeCycle = cycleCount;
            end
        end
    end

    initial begin
        logic [TW-1:0] x;
        logic [TW-1:0] y;
        r2Model   = pow2Mod(512);
        r256Model = pow2Mod(256);
        start = 1'b0;
        dataN = NMOD;
        waddr = '0;
        wdata = '0;
        rstn  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetBusy", TW'(busy), TW'(0));
        checkOutput("resetWe", TW'(we), TW'(0));
        checkOutput("resetWaddr", TW'(oWaddr), TW'(0));
        checkOutput("resetWdata", oWdata, TW'(0));
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleBusy", TW'(busy), TW'(0));

        $display("[TB] single operand x=1");
        applyStimulus(9'h011, TW'(1), 1, r2Model);
        checkOutput("busyRise", TW'(busy), TW'(1));
        endBatch();
        waitIdle(2000);

        $display("[TB] x = R mod N, then x = 0 and x = N");
        applyStimulus(9'h012, r256Model, 1, r256Model);
        endBatch();
        waitIdle(2000);
        applyStimulus(9'h014, TW'(0), 1, TW'(0));
        applyStimulus(9'h016, NMOD, 1, TW'(0));
        endBatch();
        waitIdle(3000);

        $display("[TB] burst of four random operands");
        x = randOperand(); applyStimulus(9'h011, x, 1, expectedFor(x));
        x = randOperand(); applyStimulus(9'h012, x, 1, expectedFor(x));
        x = randOperand(); applyStimulus(9'h013, x, 1, expectedFor(x));
        x = randOperand(); applyStimulus(9'h015, x, 1, expectedFor(x));
        endBatch();
        waitIdle(4000);

        $display("[TB] one push then a held push");
        x = randOperand();
        y = randOperand();
        applyStimulus(9'h022, x, 1, expectedFor(x));
        applyStimulus(9'h023, y, 3, expectedFor(y));
        endBatch();
        waitIdle(4000);

        $display("[TB] ten pushes into an eight-entry queue");
        for (int i = 0; i < 10; i++) begin
            x = randOperand();
            applyStimulus(9'h040 + 9'(i), x, 1, expectedFor(x));
        end
        endBatch();
        waitIdle(6000);

        $display("[TB] reset in the middle of phase 1");
        x = randOperand();
        applyStimulus(9'h01a, x, 1, expectedFor(x));
        endBatch();
        repeat (80) @(posedge clk);
        #1;
        rstn = 1'b1;
        expectedWrites = expectedWrites - sbQueue.size();
        sbQueue.delete();
        moreFollow     = 0;
        expectIdleNext = 0;
        @(posedge clk);
        #1;
        checkOutput("busyAfterReset", TW'(busy), TW'(0));
        rstn = 1'b0;
        batchCount = 0;
        repeat (700) @(posedge clk);
        #1;
        checkOutput("busyStaysLow", TW'(busy), TW'(0));
        checkOutput("writeCount", TW'(writeCount), TW'(expectedWrites));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
